// File: rtl/reorder_line_arbiter_pkg.sv
// Shared types and the round-robin picker for the line-reorder buffer arbiter.
package reorder_arb_pkg;

    localparam int MaxReq = 8;
    localparam int TagW   = $clog2(MaxReq);

    typedef enum logic {IDLE, FILL} arb_state_t;

    typedef struct packed {
        logic            found;
        logic [TagW-1:0] idx;
    } rr_pick_t;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] valid,
                                         input logic [TagW-1:0]   ptr,
                                         input int                num);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int k = MaxReq - 1; k >= 0; k--) begin
            if (k < num) begin
                cand = (int'(ptr) + k) % num;
                if (valid[cand[TagW-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = TagW'(cand);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reorder_line_arbiter_tag_fifo.sv
// Requester-ID FIFO tracking which port owns each line held inside the reorder buffer.
module reorder_tag_fifo #(
    parameter int Depth = 2,
    parameter int Width = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [Width-1:0] i_push_data,
    input  logic             i_pop,
    output logic [Width-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr;
    logic [PtrW-1:0]  r_rd;
    logic [CntW-1:0]  r_count;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wr <= ptr_inc(r_wr);
            end
            if (i_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_full  = (r_count == CntW'(Depth));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/reorder_line_arbiter.sv
// Shares one line-reorder buffer among NumReq streams: whole-line round-robin grants in,
// tag-routed lines out. Optional per-port line counters under REORDER_ARB_STATS_EN.
module reorder_line_arbiter
    import reorder_arb_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int NumReq    = 3,
    parameter int TagDepth  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    // Handshakes: a beat moves when valid and ready are both high at a rising edge;
    // valid never waits on ready, and a granted line is never revoked before its eol.
    input  logic [NumReq-1:0]           s_valid,
    output logic [NumReq-1:0]           s_ready,
    input  logic [NumReq*DataWidth-1:0] s_data,
    input  logic [NumReq-1:0]           s_sof,
    input  logic [NumReq-1:0]           s_eol,
    output logic                        b_in_valid,
    output logic                        b_in_sof,
    output logic                        b_in_eol,
    output logic [DataWidth-1:0]        b_in_data,
    input  logic                        b_in_ready,
    input  logic                        b_out_valid,
    input  logic                        b_out_sof,
    input  logic                        b_out_eol,
    input  logic [DataWidth-1:0]        b_out_data,
    output logic                        b_out_ready,
    output logic [NumReq-1:0]           m_valid,
    output logic [NumReq-1:0]           m_sof,
    output logic [NumReq-1:0]           m_eol,
    output logic [NumReq*DataWidth-1:0] m_data,
    input  logic [NumReq-1:0]           m_ready,
    output logic                        tag_err,
`ifdef REORDER_ARB_STATS_EN
    output logic [NumReq*16-1:0]        line_cnt,
`endif
    output arb_state_t                  o_dbg_state
);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [TagW-1:0]     r_gnt;
    logic [TagW-1:0]     r_ptr;
    logic                r_tag_err;
    rr_pick_t            w_pick;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [TagW-1:0]     w_head;
    logic                w_sel_valid;
    logic                w_sel_sof;
    logic                w_sel_eol;
    logic [DataWidth-1:0] w_sel_data;

    assign w_pick = rr_pick(MaxReq'(s_valid), r_ptr, NumReq);

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_sof   = 1'b0;
        w_sel_eol   = 1'b0;
        w_sel_data  = '0;
        s_ready     = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (r_gnt == TagW'(i)) begin
                w_sel_valid = s_valid[i];
                w_sel_sof   = s_sof[i];
                w_sel_eol   = s_eol[i];
                w_sel_data  = s_data[i*DataWidth +: DataWidth];
                s_ready[i]  = (r_state == FILL) && b_in_ready;
            end
        end
    end

    assign b_in_valid = (r_state == FILL) && w_sel_valid;
    assign b_in_sof   = w_sel_sof;
    assign b_in_eol   = w_sel_eol;
    assign b_in_data  = w_sel_data;

    // IDLE costs one bubble per line; a full tag FIFO holds the grant back.
    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick.found && !w_full) begin
                    w_push       = 1'b1;
                    w_next_state = FILL;
                end
            end
            FILL: begin
                if (w_sel_valid && b_in_ready && w_sel_eol) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_ptr     <= '0;
            r_tag_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_push) begin
                r_gnt <= w_pick.idx;
                r_ptr <= (w_pick.idx == TagW'(NumReq - 1)) ? '0 : w_pick.idx + 1'b1;
            end
            if (w_empty && b_out_valid) begin
                r_tag_err <= 1'b1;
            end
        end
    end

    reorder_tag_fifo #(
        .Depth (TagDepth),
        .Width (TagW)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_pick.idx),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        m_valid     = '0;
        m_sof       = '0;
        m_eol       = '0;
        b_out_ready = 1'b0;
        if (!w_empty) begin
            for (int i = 0; i < NumReq; i++) begin
                if (w_head == TagW'(i)) begin
                    m_valid[i]  = b_out_valid;
                    m_sof[i]    = b_out_sof;
                    m_eol[i]    = b_out_eol;
                    b_out_ready = m_ready[i];
                end
            end
        end
    end

    assign w_pop       = !w_empty && b_out_valid && b_out_ready && b_out_eol;
    assign m_data      = {NumReq{b_out_data}};
    assign tag_err     = r_tag_err;
    assign o_dbg_state = r_state;

`ifdef REORDER_ARB_STATS_EN
    logic [NumReq*16-1:0] r_line_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_cnt <= '0;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (m_valid[i] && m_ready[i] && m_eol[i]) begin
                    r_line_cnt[i*16 +: 16] <= r_line_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign line_cnt = r_line_cnt;
`endif

endmodule

// File: tb/tb_reorder_line_arbiter.sv
// Bench for reorder_line_arbiter: source and reorder-buffer models, per-port scoreboard.
module tb_reorder_line_arbiter;
    import reorder_arb_pkg::*;

    localparam int DW = 16;
    localparam int NR = 3;
    localparam int TD = 2;
    localparam int W  = DW + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    s_valid, s_ready, s_sof, s_eol;
    logic [NR*DW-1:0] s_data;
    logic             b_in_valid, b_in_sof, b_in_eol, b_in_ready;
    logic [DW-1:0]    b_in_data;
    logic             b_out_valid, b_out_sof, b_out_eol, b_out_ready;
    logic [DW-1:0]    b_out_data;
    logic [NR-1:0]    m_valid, m_sof, m_eol, m_ready;
    logic [NR*DW-1:0] m_data;
    logic             tag_err;
    arb_state_t       dbg_state;
`ifdef REORDER_ARB_STATS_EN
    logic [NR*16-1:0] line_cnt;
`endif

    logic mdl_valid, force_err, out_en, tog, in_stall;
    assign b_out_valid = mdl_valid | force_err;

    reorder_line_arbiter #(.DataWidth(DW), .NumReq(NR), .TagDepth(TD)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
        .b_in_valid(b_in_valid), .b_in_sof(b_in_sof), .b_in_eol(b_in_eol),
        .b_in_data(b_in_data), .b_in_ready(b_in_ready),
        .b_out_valid(b_out_valid), .b_out_sof(b_out_sof), .b_out_eol(b_out_eol),
        .b_out_data(b_out_data), .b_out_ready(b_out_ready),
        .m_valid(m_valid), .m_sof(m_sof), .m_eol(m_eol), .m_data(m_data), .m_ready(m_ready),
        .tag_err(tag_err),
`ifdef REORDER_ARB_STATS_EN
        .line_cnt(line_cnt),
`endif
        .o_dbg_state(dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] src_q [NR][$];
    logic [W-1:0] exp_q [NR][$];
    logic [W-1:0] cur_line[$];
    logic [W-1:0] out_q[$];
    int           gnt_log[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Beats are {sof, eol, data}; expected output is evens then odds.
    function automatic void push_line(input int r, input logic [DW-1:0] base, input int n,
                                      input bit with_exp);
        int j;
        for (int k = 0; k < n; k++) src_q[r].push_back({k == 0, k == n - 1, base + DW'(k)});
        if (with_exp) begin
            j = 0;
            for (int k = 0; k < n; k += 2) begin
                exp_q[r].push_back({j == 0, j == n - 1, base + DW'(k)});
                j++;
            end
            for (int k = 1; k < n; k += 2) begin
                exp_q[r].push_back({j == 0, j == n - 1, base + DW'(k)});
                j++;
            end
        end
    endfunction

    function automatic bit drained();
        bit d;
        d = (cur_line.size() == 0) && (out_q.size() == 0) && (dbg_state == IDLE);
        for (int r = 0; r < NR; r++) if (src_q[r].size() != 0 || exp_q[r].size() != 0) d = 0;
        return d;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int c;
        bit done;
        c = 0;
        done = drained();
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
            done = drained();
        end
        check({name, "_drain"}, done, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_b_in_valid"}, b_in_valid, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_b_out_ready"}, b_out_ready, 0);
        check({tag, "_tag_err"}, tag_err, 0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    // Requester model: one queue of beats per port.
    initial begin
        logic [NR-1:0] hs;
        logic rs;
        s_valid = '0; s_sof = '0; s_eol = '0; s_data = '0;
        forever begin
            @(negedge clk);
            hs = s_valid & s_ready;
            rs = rst;
            @(posedge clk); #1;
            for (int r = 0; r < NR; r++) begin
                if (rs) src_q[r].delete();
                else if (hs[r]) void'(src_q[r].pop_front());
                if (src_q[r].size() > 0) begin
                    s_valid[r] = 1'b1;
                    {s_sof[r], s_eol[r], s_data[r*DW +: DW]} = src_q[r][0];
                end else begin
                    s_valid[r] = 1'b0; s_sof[r] = 1'b0; s_eol[r] = 1'b0;
                end
            end
        end
    end

    // Reorder buffer model: collects a whole line, then releases evens then odds.
    initial begin
        logic in_hs, out_hs, rs;
        logic [W-1:0] in_beat;
        int n, j;
        mdl_valid = 1'b0; b_out_sof = 1'b0; b_out_eol = 1'b0; b_out_data = '0;
        m_ready = '1; b_in_ready = 1'b1;
        forever begin
            @(negedge clk);
            in_hs   = b_in_valid & b_in_ready;
            in_beat = {b_in_sof, b_in_eol, b_in_data};
            out_hs  = mdl_valid & b_out_ready;
            rs      = rst;
            @(posedge clk); #1;
            if (rs) begin
                cur_line.delete();
                out_q.delete();
            end else begin
                if (out_hs) void'(out_q.pop_front());
                if (in_hs) begin
                    cur_line.push_back(in_beat);
                    if (in_beat[DW]) begin
                        n = cur_line.size();
                        j = 0;
                        for (int k = 0; k < n; k += 2) begin
                            out_q.push_back({(j == 0) & cur_line[0][DW+1], j == n - 1, cur_line[k][DW-1:0]});
                            j++;
                        end
                        for (int k = 1; k < n; k += 2) begin
                            out_q.push_back({1'b0, j == n - 1, cur_line[k][DW-1:0]});
                            j++;
                        end
                        cur_line.delete();
                    end
                end
            end
            mdl_valid = out_en && (out_q.size() > 0);
            if (out_q.size() > 0) {b_out_sof, b_out_eol, b_out_data} = out_q[0];
            if (tog) m_ready[0] = ~m_ready[0];
            else m_ready = '1;
            b_in_ready = in_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Output scoreboard and grant log.
    initial begin
        logic [W-1:0] got, e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < NR; i++) begin
                    if (m_valid[i] && m_ready[i]) begin
                        got = {m_sof[i], m_eol[i], m_data[i*DW +: DW]};
                        if (exp_q[i].size() == 0) begin
                            check($sformatf("out_port%0d_unexpected", i), got, 0);
                        end else begin
                            e = exp_q[i].pop_front();
                            check($sformatf("out_port%0d", i), got, e);
                        end
                    end
                end
                if (m_valid != '0) check("m_valid_onehot", $countones(m_valid) <= 1, 1);
                if (b_in_valid && b_in_ready && b_in_sof)
                    for (int i = 0; i < NR; i++) if (s_ready[i]) gnt_log.push_back(i);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic [NR-1:0] valid;
        int            n;
        int            order[3];
    } arb_vec_t;

    initial begin
        arb_vec_t vecs[9];
        bit found;
        int c;
        force_err = 1'b0; out_en = 1'b1; tog = 1'b0; in_stall = 1'b0;
        vecs[0] = '{3'b111, 3, '{0, 1, 2}};
        vecs[1] = '{3'b110, 2, '{1, 2, 0}};
        vecs[2] = '{3'b100, 1, '{2, 0, 0}};
        vecs[3] = '{3'b011, 2, '{0, 1, 0}};
        vecs[4] = '{3'b101, 2, '{2, 0, 0}};
        vecs[5] = '{3'b101, 2, '{2, 0, 0}};
        vecs[6] = '{3'b001, 1, '{0, 0, 0}};
        vecs[7] = '{3'b011, 2, '{1, 0, 0}};
        vecs[8] = '{3'b110, 2, '{1, 2, 0}};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        for (int v = 0; v < 9; v++) begin
            gnt_log.delete();
            for (int r = 0; r < NR; r++)
                if (vecs[v].valid[r]) push_line(r, DW'(16'h100 * (v + 1) + 16 * r), 1, 1);
            wait_drain($sformatf("arb_v%0d", v), 100);
            check($sformatf("arb_v%0d_count", v), gnt_log.size(), vecs[v].n);
            for (int k = 0; k < vecs[v].n; k++)
                check($sformatf("arb_v%0d_g%0d", v, k), (k < gnt_log.size()) ? gnt_log[k] : -1,
                      vecs[v].order[k]);
        end

        // Fairness: every requester keeps two 4-beat lines queued, input side stalls randomly.
        gnt_log.delete();
        in_stall = 1'b1;
        for (int rep = 0; rep < 2; rep++)
            for (int r = 0; r < NR; r++) push_line(r, DW'(16'h2000 + rep * 16'h100 + r * 16'h10), 4, 1);
        wait_drain("rr", 400);
        in_stall = 1'b0;
        check("rr_count", gnt_log.size(), 6);
        for (int k = 0; k < 6; k++)
            check($sformatf("rr_g%0d", k), (k < gnt_log.size()) ? gnt_log[k] : -1, k % 3);

        // Single requester with literal reordered expectation.
        push_line(1, 16'h0000, 8, 0);
        begin
            int ord[8];
            ord = '{0, 2, 4, 6, 1, 3, 5, 7};
            for (int j = 0; j < 8; j++) exp_q[1].push_back({j == 0, j == 7, DW'(ord[j])});
        end
        c = 0;
        while (!drained() && c < 200) begin
            @(negedge clk);
            c++;
            check("t1_other_m_valid", m_valid & 3'b101, 0);
            if (m_valid[1]) check("t1_s_ready_drain", s_ready, 0);
        end
        check("t1_drain", drained(), 1);

        // Consumer backpressure on port 0, then a line for port 1.
        gnt_log.delete();
        tog = 1'b1;
        push_line(0, 16'h3000, 8, 1);
        push_line(1, 16'h3100, 4, 1);
        wait_drain("bp", 300);
        tog = 1'b0;
        check("bp_count", gnt_log.size(), 2);
        check("bp_g0", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
        check("bp_g1", (gnt_log.size() > 1) ? gnt_log[1] : -1, 1);

        // Tag FIFO full: buffer output held off, third line must wait for the first pop.
        gnt_log.delete();
        out_en = 1'b0;
        for (int r = 0; r < NR; r++) push_line(r, DW'(16'h4000 + r * 16'h100), 4, 1);
        repeat (40) @(negedge clk);
        check("full_grants", gnt_log.size(), TD);
        check("full_s_ready", s_ready, 0);
        check("full_b_in_valid", b_in_valid, 0);
        check("full_state", dbg_state, IDLE);
        out_en = 1'b1;
        found = 0;
        c = 0;
        while (!found && c < 60) begin
            @(negedge clk);
            c++;
            found = m_valid[2] && m_ready[2] && m_eol[2];
        end
        check("full_first_pop", found, 1);
        check("full_pop_cycle_s_ready", s_ready, 0);
        @(negedge clk);
        check("full_after_pop_s_ready", s_ready, 0);
        check("full_after_pop_state", dbg_state, IDLE);
        @(negedge clk);
        check("full_regrant_s_ready", s_ready, 3'b010);
        wait_drain("full", 300);
        check("full_count", gnt_log.size(), 3);
        check("full_g0", (gnt_log.size() > 0) ? gnt_log[0] : -1, 2);
        check("full_g1", (gnt_log.size() > 1) ? gnt_log[1] : -1, 0);
        check("full_g2", (gnt_log.size() > 2) ? gnt_log[2] : -1, 1);

        // Buffer beat with no tag outstanding.
        @(posedge clk); #1 force_err = 1'b1;
        @(negedge clk);
        check("err_m_valid", m_valid, 0);
        check("err_b_out_ready", b_out_ready, 0);
        check("err_before_edge", tag_err, 0);
        @(posedge clk); #1 force_err = 1'b0;
        @(negedge clk);
        check("err_set", tag_err, 1);
        repeat (5) @(negedge clk);
        check("err_sticky", tag_err, 1);
        check("err_m_valid_after", m_valid, 0);

        // Reset in the middle of a line from requester 2.
        push_line(2, 16'h5000, 8, 0);
        c = 0;
        while (src_q[2].size() > 5 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("rst_mid_reached", src_q[2].size() <= 5, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
`ifdef REORDER_ARB_STATS_EN
        check("rst_mid_line_cnt", line_cnt, 0);
`endif
        gnt_log.delete();
        push_line(2, 16'h6000, 8, 1);
        wait_drain("rst_line", 200);
        check("rst_line_count", gnt_log.size(), 1);
        check("rst_line_g0", (gnt_log.size() > 0) ? gnt_log[0] : -1, 2);
`ifdef REORDER_ARB_STATS_EN
        check("rst_line_cnt2", line_cnt, {16'd1, 16'd0, 16'd0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
